mmio_bus_controller: RTL
========================

// Module: mmio_bus_controller
// PURPOSE
//  Sits between the processor data port and the data RAM. Decodes the memory-mapped I/O window.
//  Captures debounced button presses as saturating event counts that are cleared when read.
//  Registers processor writes bound for the VGA controller and steers read data back to q_dmem.
//  Prevents MMIO addresses from aliasing into the 12-bit RAM.
// PARAMETERS
//  DATA_W     32    data bus width
//  CNT_W      4     per-button event counter width (saturating)
//  BTNC_ADDR  1000  read: centre-button event count
//  OUT_ADDR   2000  write: VGA command word; read: last word written
//  BTNL_ADDR  3000  read: left-button event count
//  BTNR_ADDR  4000  read: right-button event count
//  BTNU_ADDR  5000  read: up-button event count
//  BTND_ADDR  6000  read: down-button event count
// PORTS
//  clock         in   1       processor clock (25 MHz)
//  reset         in   1       asynchronous, active-low
//  address_dmem  in   32      processor data address
//  wren          in   1       processor store strobe
//  data          in   32      processor store data
//  ram_q         in   32      RAM read data (RAM reads synchronously, 1-cycle latency)
//  ram_wren      out  1       RAM write enable (gated)
//  q_dmem        out  32      read data to processor
//  btn_in        in   5       debounced buttons {D,U,R,L,C}, level
//  vga_cmd       out  32      last word written to OUT_ADDR
//  vga_cmd_valid out  1       1-cycle pulse per write to OUT_ADDR
//  btn_pending   out  5       per-button (count != 0), for debug LEDs
// BEHAVIOUR
//  Reset values (asserted while reset==0)
//   - All outputs 0.
//   - All counters 0; btn_prev 0.
//   - read-source register = SRC_ZERO.
//  Decode (combinational)
//   - mmio_hit = address matches any of the six MMIO addresses, full 32-bit compare.
//   - ram_wren = wren & ~mmio_hit.
//  Button path (per button i)
//   - rise_i = btn_in[i] & ~btn_prev[i]; btn_prev registered every cycle.
//   - rd_i = ~wren & address == BTNx_ADDR.
//   - cnt_next = (rd_i ? 0 : cnt) + rise_i, saturating at 2^CNT_W-1.
//   - Read and press in the same cycle: the read returns the old count; the counter becomes 1.
//     No press is ever lost.
//   - At 15, further presses hold the counter at 15; there is no wrap-around.
//   - Writes to button addresses are ignored: no counter change, no RAM write.
//  Read path, latency 1 cycle, aligned with ram_q
//   - At a clock edge with ~wren, register src:
//     SRC_BTN (button address; also capture the zero-extended count), SRC_OUT (OUT_ADDR),
//     otherwise SRC_RAM.
//   - If wren, src <= SRC_ZERO.
//   - q_dmem = src==SRC_RAM ? ram_q : src==SRC_BTN ? captured count
//              : src==SRC_OUT ? vga_cmd : 0.
//   - Back-to-back reads to different sources are each returned exactly 1 cycle after their
//     address.
//  Write path
//   - On wren & address==OUT_ADDR: vga_cmd <= data and vga_cmd_valid <= 1 for exactly one cycle.
//   - Consecutive writes give consecutive pulses, and vga_cmd updates each cycle.
//   - vga_cmd holds its value until the next write.
//  Reset mid-operation
//   - Counters clear and any pending read returns 0.
//   - vga_cmd_valid drops immediately (asynchronous).
// STRUCTURE
//  - mmio_pkg holds: the six address constants, the src enum {SRC_ZERO, SRC_RAM, SRC_BTN,
//    SRC_OUT}, button index constants BTN_C=0..BTN_D=4, CNT_W.
//  - Sub-module btn_event_counter holds edge detect, saturating counter and read-clear.
//    It is instanced 5 times.
//  - The top level holds decode, the read-source pipeline register and the VGA command register.
// TESTING
//  - Press BTNC 3 times (separate rising edges), then load 1000 -> q_dmem=3 one cycle later.
//    A second load returns 0.
//  - 20 BTNL presses -> load 3000 returns 15 (saturation); btn_pending[1]=1 before the read,
//    0 after.
//  - BTNU rises in the same cycle as a load of 5000 (count 2) -> returns 2; the next load
//    returns 1.
//  - Store 0xDEADBEEF to 2000 -> vga_cmd=0xDEADBEEF and vga_cmd_valid high for 1 cycle;
//    ram_wren=0. Load 2000 -> 0xDEADBEEF.
//  - Store 0x55 to 0x010, then load 0x010 -> ram_wren=1 on the store; q_dmem=0x55 one cycle
//    after the load. A load of 1000 in the next cycle is returned the cycle after.
//  - Assert reset (0) with counters nonzero and a read in flight -> all outputs and counters 0
//    immediately; the first read after release returns a correct value.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO bus controller.
package mmio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned N_BTN  = 5;

    localparam logic [ADDR_W-1:0] BTNC_ADDR = 32'd1000;
    localparam logic [ADDR_W-1:0] OUT_ADDR  = 32'd2000;
    localparam logic [ADDR_W-1:0] BTNL_ADDR = 32'd3000;
    localparam logic [ADDR_W-1:0] BTNR_ADDR = 32'd4000;
    localparam logic [ADDR_W-1:0] BTNU_ADDR = 32'd5000;
    localparam logic [ADDR_W-1:0] BTND_ADDR = 32'd6000;

    // Bit positions inside btn_in / btn_pending: {D,U,R,L,C}
    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_L = 1;
    localparam int unsigned BTN_R = 2;
    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_D = 4;

    // Which source drives q_dmem in the cycle after a load
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_BTN  = 2'd2,
        SRC_OUT  = 2'd3
    } src_e;

    // Maps a button index to its read address
    function automatic logic [ADDR_W-1:0] btn_addr(input int unsigned idx);
        case (idx)
            BTN_C:   btn_addr = BTNC_ADDR;
            BTN_L:   btn_addr = BTNL_ADDR;
            BTN_R:   btn_addr = BTNR_ADDR;
            BTN_U:   btn_addr = BTNU_ADDR;
            default: btn_addr = BTND_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/btn_event_counter.sv
// Per-button rising-edge detector with a saturating, clear-on-read event counter.
module btn_event_counter
    import mmio_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             btn,
    input  logic             rd,
    output logic [CNT_W-1:0] cnt,
    output logic             pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_c;
    logic [CNT_W-1:0] base_c;

    // A read clears first, then a same-cycle press is added so it is never lost
    always_comb begin
        prev_d = btn;
        rise_c = btn & ~prev_q;
        base_c = rd ? '0 : cnt_q;
        cnt_d  = base_c;
        if (rise_c && (base_c != CNT_MAX)) begin
            cnt_d = base_c + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign pending = (cnt_q != '0);

endmodule

// File: rtl/mmio_bus_controller.sv
// Decodes the MMIO window between the CPU data port and the data RAM.
module mmio_bus_controller
    import mmio_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_dmem,
    input  logic              wren,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              ram_wren,
    output logic [DATA_W-1:0] q_dmem,
    input  logic [N_BTN-1:0]  btn_in,
    output logic [DATA_W-1:0] vga_cmd,
    output logic              vga_cmd_valid,
    output logic [N_BTN-1:0]  btn_pending
);

    logic [N_BTN-1:0] btn_hit_c;
    logic [N_BTN-1:0] btn_rd_c;
    logic             out_hit_c;
    logic             mmio_hit_c;
    logic [CNT_W-1:0] cnt_w [N_BTN];
    logic [CNT_W-1:0] cnt_sel_c;

    src_e              src_q, src_d;
    logic [CNT_W-1:0]  cap_q, cap_d;
    logic [DATA_W-1:0] vga_cmd_q, vga_cmd_d;
    logic              vga_valid_q, vga_valid_d;

    // One counter per button, each with its own full-address read strobe
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        assign btn_hit_c[g] = (address_dmem == btn_addr(g));
        assign btn_rd_c[g]  = btn_hit_c[g] & ~wren;

        btn_event_counter u_cnt (
            .clock   (clock),
            .reset   (reset),
            .btn     (btn_in[g]),
            .rd      (btn_rd_c[g]),
            .cnt     (cnt_w[g]),
            .pending (btn_pending[g])
        );
    end

    // Full 32-bit decode keeps MMIO stores out of the 12-bit RAM
    always_comb begin
        out_hit_c  = (address_dmem == OUT_ADDR);
        mmio_hit_c = (|btn_hit_c) | out_hit_c;
        ram_wren   = wren & ~mmio_hit_c & reset;
    end

    // Selects the count of whichever button address is presented
    always_comb begin
        cnt_sel_c = '0;
        case (address_dmem)
            BTNC_ADDR: cnt_sel_c = cnt_w[BTN_C];
            BTNL_ADDR: cnt_sel_c = cnt_w[BTN_L];
            BTNR_ADDR: cnt_sel_c = cnt_w[BTN_R];
            BTNU_ADDR: cnt_sel_c = cnt_w[BTN_U];
            BTND_ADDR: cnt_sel_c = cnt_w[BTN_D];
            default:   cnt_sel_c = '0;
        endcase
    end

    // Read-source pipeline and VGA command register next-state
    always_comb begin
        src_d       = src_q;
        cap_d       = cap_q;
        vga_cmd_d   = vga_cmd_q;
        vga_valid_d = 1'b0;
        if (wren) begin
            src_d = SRC_ZERO;
            if (out_hit_c) begin
                vga_cmd_d   = data;
                vga_valid_d = 1'b1;
            end
        end else if (|btn_hit_c) begin
            src_d = SRC_BTN;
            cap_d = cnt_sel_c;
        end else if (out_hit_c) begin
            src_d = SRC_OUT;
        end else begin
            src_d = SRC_RAM;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_q       <= SRC_ZERO;
            cap_q       <= '0;
            vga_cmd_q   <= '0;
            vga_valid_q <= 1'b0;
        end else begin
            src_q       <= src_d;
            cap_q       <= cap_d;
            vga_cmd_q   <= vga_cmd_d;
            vga_valid_q <= vga_valid_d;
        end
    end

    // Read data steering, aligned with the RAM's one-cycle read latency
    always_comb begin
        case (src_q)
            SRC_RAM: q_dmem = ram_q;
            SRC_BTN: q_dmem = DATA_W'(cap_q);
            SRC_OUT: q_dmem = vga_cmd_q;
            default: q_dmem = '0;
        endcase
    end

    assign vga_cmd       = vga_cmd_q;
    assign vga_cmd_valid = vga_valid_q;

endmodule
